// File: rtl/io_pkg.sv
// Shared definitions for board input conditioning: sync reset levels, key FSM states, width helper.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package io_pkg;

    // Synchronizer reset levels: keys idle high (released), switches idle low (off).
    localparam logic KEY_SYNC_RST = 1'b1;
    localparam logic SW_SYNC_RST  = 1'b0;

    // Key press/hold state machine encoding.
    typedef logic [1:0] key_st_t;
    localparam key_st_t KS_IDLE    = 2'd0;
    localparam key_st_t KS_PRESSED = 2'd1;
    localparam key_st_t KS_HELD    = 2'd2;

    // Bits needed for a counter that runs 0..max_val-1, never narrower than 1.
    function automatic int cw(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One-bit 2-flop synchronizer plus tick-based debounce; o_chg pulses in the cycle o_level updates.
// Latency: 2 cycles sync plus DB_TICKS debounce ticks from raw change to o_level.
// Backpressure: none; free-running, every accepted edge is reported exactly once.
module debounce_ch
    import io_pkg::*;
#(
    parameter int   DB_TICKS = 10,
    parameter logic SYNC_RST = 1'b0,
    parameter logic INV      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_chg
);

    localparam int            CW   = cw(DB_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic [1:0]    r_sync;
    logic          r_s;
    logic [CW-1:0] r_cnt;
    logic          r_chg;
    logic          w_in;

    // Two-stage synchronizer; reset to the idle level of the pin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {2{SYNC_RST}};
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Keys are active-low on the pin; flip them so 1 always means "active" internally.
    assign w_in = r_sync[1] ^ INV;

    // Accept a new level only after DB_TICKS ticks of uninterrupted disagreement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s   <= 1'b0;
            r_cnt <= '0;
            r_chg <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (w_in == r_s) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == LAST) begin
                    r_s   <= w_in;
                    r_cnt <= '0;
                    r_chg <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_s;
    assign o_chg   = r_chg;

endmodule

// File: rtl/board_inputs.sv
// Conditions raw keys and switches into debounced levels, edge pulses and key long-press events.
// Latency: 2 sync cycles + DB_TICKS ticks + 1 registered output cycle from pin to outputs.
// Backpressure: none; outputs are 1-cycle pulses/levels, consumers must sample every cycle.
module board_inputs
    import io_pkg::*;
#(
    parameter int NKEY       = 4,
    parameter int NSW        = 10,
    parameter int TICK_DIV   = 50000,
    parameter int DB_TICKS   = 10,
    parameter int LONG_TICKS = 1000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NKEY-1:0] i_key_n,
    input  logic [NSW-1:0]  i_sw,
    output logic [NKEY-1:0] o_key_down,
    output logic [NKEY-1:0] o_key_press,
    output logic [NKEY-1:0] o_key_release,
    output logic [NKEY-1:0] o_key_long,
    output logic [NKEY-1:0] o_key_held,
    output logic [NSW-1:0]  o_sw_out,
    output logic            o_sw_chg
);

    localparam int            PW    = cw(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam int            HW    = cw(LONG_TICKS);
    localparam logic [HW-1:0] HLAST = HW'(LONG_TICKS - 1);

    logic [PW-1:0]   r_pre;
    logic            w_tick;
    logic [NKEY-1:0] w_key_lvl;
    logic [NKEY-1:0] w_key_chg;
    logic [NSW-1:0]  w_sw_lvl;
    logic [NSW-1:0]  w_sw_chg;
    logic [NSW-1:0]  r_sw_out;
    logic            r_sw_chg;

    // Shared debounce prescaler: one tick every TICK_DIV cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = (r_pre == PLAST);

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        key_st_t       r_state;
        logic [HW-1:0] r_hold;
        logic          r_down;
        logic          r_press;
        logic          r_release;
        logic          r_long;
        logic          r_held;

        debounce_ch #(
            .DB_TICKS (DB_TICKS),
            .SYNC_RST (KEY_SYNC_RST),
            .INV      (1'b1)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_key_n[k]),
            .i_tick  (w_tick),
            .o_level (w_key_lvl[k]),
            .o_chg   (w_key_chg[k])
        );

        // Press/hold FSM; a debounced change in IDLE is a press, elsewhere a release.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state   <= KS_IDLE;
                r_hold    <= '0;
                r_down    <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_held    <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_down    <= w_key_lvl[k];
                case (r_state)
                    KS_IDLE: begin
                        if (w_key_chg[k]) begin
                            r_state <= KS_PRESSED;
                            r_press <= 1'b1;
                            r_hold  <= '0;
                        end
                    end
                    KS_PRESSED: begin
                        if (w_key_chg[k]) begin
                            r_state   <= KS_IDLE;
                            r_release <= 1'b1;
                        end else if (w_tick) begin
                            if (r_hold == HLAST) begin
                                r_state <= KS_HELD;
                                r_long  <= 1'b1;
                                r_held  <= 1'b1;
                            end else begin
                                r_hold <= r_hold + 1'b1;
                            end
                        end
                    end
                    KS_HELD: begin
                        if (w_key_chg[k]) begin
                            r_state   <= KS_IDLE;
                            r_release <= 1'b1;
                            r_held    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= KS_IDLE;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end

        assign o_key_down[k]    = r_down;
        assign o_key_press[k]   = r_press;
        assign o_key_release[k] = r_release;
        assign o_key_long[k]    = r_long;
        assign o_key_held[k]    = r_held;
    end

    for (genvar s = 0; s < NSW; s++) begin : g_sw
        debounce_ch #(
            .DB_TICKS (DB_TICKS),
            .SYNC_RST (SW_SYNC_RST),
            .INV      (1'b0)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_sw[s]),
            .i_tick  (w_tick),
            .o_level (w_sw_lvl[s]),
            .o_chg   (w_sw_chg[s])
        );
    end

    // Register switch levels and the combined change flag together so they stay aligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw_out <= '0;
            r_sw_chg <= 1'b0;
        end else begin
            r_sw_out <= w_sw_lvl;
            r_sw_chg <= |w_sw_chg;
        end
    end

    assign o_sw_out = r_sw_out;
    assign o_sw_chg = r_sw_chg;

endmodule

// File: tb/tb_board_inputs.sv
module tb_board_inputs;

    logic       clk;
    logic       rst;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic [3:0] key_down, key_press, key_release, key_long, key_held;
    logic [9:0] sw_out;
    logic       sw_chg;
    logic [30:0] all_out;

    int checks = 0;
    int errors = 0;

    board_inputs #(
        .NKEY       (4),
        .NSW        (10),
        .TICK_DIV   (4),
        .DB_TICKS   (3),
        .LONG_TICKS (5)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_n       (key_n),
        .i_sw          (sw),
        .o_key_down    (key_down),
        .o_key_press   (key_press),
        .o_key_release (key_release),
        .o_key_long    (key_long),
        .o_key_held    (key_held),
        .o_sw_out      (sw_out),
        .o_sw_chg      (sw_chg)
    );

    assign all_out = {key_down, key_press, key_release, key_long, key_held, sw_out, sw_chg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1; key_n = 4'hF; sw = 10'h000;
        cyc(3);
        checks++;
        if (all_out !== 31'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_out);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (all_out !== 31'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL idle_no_pulses got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_press_release;
        int n;
        key_n[0] = 1'b0;
        n = 0;
        while (key_down[0] !== 1'b1 && n < 16) begin cyc(1); n++; end
        checks++;
        if (key_down[0] !== 1'b1) begin
            errors++; $display("FAIL press_latency key_down0 got %b after %0d cycles want 1", key_down[0], n);
        end
        checks++;
        if (key_press !== 4'b0001) begin
            errors++; $display("FAIL press_with_down got %b want 0001", key_press);
        end
        cyc(1);
        checks++;
        if (key_press !== 4'b0000 || key_down !== 4'b0001) begin
            errors++; $display("FAIL press_one_cycle press=%b down=%b want 0000/0001", key_press, key_down);
        end
        key_n[0] = 1'b1;
        n = 0;
        while (key_release[0] !== 1'b1 && n < 16) begin cyc(1); n++; end
        checks++;
        if (key_release !== 4'b0001 || key_down !== 4'b0000) begin
            errors++; $display("FAIL release rel=%b down=%b want 0001/0000", key_release, key_down);
        end
        cyc(1);
        checks++;
        if (key_release !== 4'b0000) begin
            errors++; $display("FAIL release_one_cycle got %b want 0000", key_release);
        end
    endtask

    task automatic test_glitch;
        int bad;
        bad = 0;
        for (int r = 0; r < 10; r++) begin
            key_n[1] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cyc(1);
                if ((key_down | key_press | key_release | key_long | key_held) !== 4'b0000) bad++;
            end
            key_n[1] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cyc(1);
                if ((key_down | key_press | key_release | key_long | key_held) !== 4'b0000) bad++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if ((key_down | key_press | key_release | key_long | key_held) !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL glitch_rejected got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_long;
        int n, t, longs;
        key_n[2] = 1'b0;
        t = 0;
        while (key_press[2] !== 1'b1 && t < 16) begin cyc(1); t++; end
        checks++;
        if (key_press !== 4'b0100) begin
            errors++; $display("FAIL long_press_seen got %b want 0100", key_press);
        end
        // Press lands on the edge after a tick, so the fifth following tick is 19 cycles later.
        n = 0;
        while (key_long[2] !== 1'b1 && n < 30) begin cyc(1); n++; end
        t += n;
        checks++;
        if (n !== 19) begin
            errors++; $display("FAIL long_latency got %0d cycles want 19", n);
        end
        checks++;
        if (key_long !== 4'b0100 || key_held !== 4'b0100) begin
            errors++; $display("FAIL long_held long=%b held=%b want 0100/0100", key_long, key_held);
        end
        longs = 0;
        while (t < 40) begin
            cyc(1); t++;
            if (key_long[2] === 1'b1) longs++;
        end
        key_n[2] = 1'b1;
        n = 0;
        while (key_release[2] !== 1'b1 && n < 16) begin
            cyc(1); n++;
            if (key_long[2] === 1'b1) longs++;
        end
        checks++;
        if (key_release !== 4'b0100 || key_held !== 4'b0000) begin
            errors++; $display("FAIL long_release rel=%b held=%b want 0100/0000", key_release, key_held);
        end
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (key_long[2] === 1'b1) longs++;
        end
        checks++;
        if (longs !== 0 || key_held !== 4'b0000) begin
            errors++; $display("FAIL long_single extra=%0d held=%b want 0/0000", longs, key_held);
        end
    endtask

    task automatic test_switch;
        int n, extra;
        rst = 1'b1; sw = 10'h3FF;
        cyc(2);
        rst = 1'b0;
        n = 0;
        while (sw_chg !== 1'b1 && n < 20) begin cyc(1); n++; end
        checks++;
        if (sw_chg !== 1'b1 || sw_out !== 10'h3FF) begin
            errors++; $display("FAIL sw_initial chg=%b out=%h want 1/3ff", sw_chg, sw_out);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); if (sw_chg === 1'b1) extra++; end
        checks++;
        if (extra !== 0 || sw_out !== 10'h3FF) begin
            errors++; $display("FAIL sw_initial_single extra=%0d out=%h want 0/3ff", extra, sw_out);
        end
        sw[9] = 1'b0;
        n = 0;
        while (sw_chg !== 1'b1 && n < 20) begin cyc(1); n++; end
        checks++;
        if (sw_chg !== 1'b1 || sw_out !== 10'h1FF) begin
            errors++; $display("FAIL sw_toggle chg=%b out=%h want 1/1ff", sw_chg, sw_out);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); if (sw_chg === 1'b1) extra++; end
        checks++;
        if (extra !== 0 || sw_out !== 10'h1FF) begin
            errors++; $display("FAIL sw_toggle_single extra=%0d out=%h want 0/1ff", extra, sw_out);
        end
        sw = 10'h000;
        cyc(30);
    endtask

    task automatic test_reset_mid;
        int n, rels;
        key_n[3] = 1'b0;
        cyc(6);
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 31'd0) begin
            errors++; $display("FAIL rst_mid_debounce got %h want 0", all_out);
        end
        cyc(2);
        rst = 1'b0;
        n = 0; rels = 0;
        while (key_press[3] !== 1'b1 && n < 16) begin
            cyc(1); n++;
            if (key_release[3] === 1'b1) rels++;
        end
        checks++;
        if (key_press !== 4'b1000 || rels !== 0) begin
            errors++; $display("FAIL rst_fresh_press press=%b rels=%0d want 1000/0", key_press, rels);
        end
        n = 0;
        while (key_held[3] !== 1'b1 && n < 30) begin cyc(1); n++; end
        checks++;
        if (key_held !== 4'b1000 || key_down !== 4'b1000) begin
            errors++; $display("FAIL held_before_rst held=%b down=%b want 1000/1000", key_held, key_down);
        end
        cyc(3);
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 31'd0) begin
            errors++; $display("FAIL rst_mid_hold got %h want 0", all_out);
        end
        cyc(2);
        rst = 1'b0;
        n = 0; rels = 0;
        while (key_press[3] !== 1'b1 && n < 16) begin
            cyc(1); n++;
            if (key_release[3] === 1'b1) rels++;
        end
        checks++;
        if (key_press !== 4'b1000 || rels !== 0 || key_held !== 4'b0000) begin
            errors++; $display("FAIL rst_hold_fresh_press press=%b rels=%0d held=%b want 1000/0/0000", key_press, rels, key_held);
        end
        key_n[3] = 1'b1;
        n = 0;
        while (key_release[3] !== 1'b1 && n < 16) begin cyc(1); n++; end
        checks++;
        if (key_release !== 4'b1000 || key_down !== 4'b0000) begin
            errors++; $display("FAIL rst_final_release rel=%b down=%b want 1000/0000", key_release, key_down);
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 4'hF; sw = 10'h000;
        test_reset;
        test_press_release;
        test_glitch;
        test_long;
        test_switch;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
